// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation engine.
package rsa_pkg;

   // Default operand / result width.
   localparam int RSA_DATA_BW_DEFAULT = 32;

   // Engine sequencing states.
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      REDUCE,
      EXP,
      DONE
   } rsa_state_t;

   // Cycles from the accept edge to the edge that raises RSA_ready:
   // 1 (LOAD) + W (REDUCE) + W*(W+1) (EXP) + 1 (DONE).
   function automatic int rsa_latency(input int w);
      return w * (w + 2) + 2;
   endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial modular multiplier: p = a*b mod m, for a, b < m.
// The caller holds a, b and m stable from start until done.
// One start cycle, W-1 further iteration cycles, then a one-cycle done flag.
module rsa_modmul #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] m,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] p
);

   localparam int CW = $clog2(W);

   // acc stays below 3m after the add, so W+2 bits never overflow.
   logic [W+1:0]  acc;
   logic [CW-1:0] idx;

   // One MSB-first step: acc = 2*acc + (bit ? b : 0), then up to two subtractions of m.
   function automatic logic [W+1:0] mm_step(input logic [W+1:0] acc_in,
                                            input logic         add_b,
                                            input logic [W-1:0] b_in,
                                            input logic [W-1:0] m_in);
      logic [W+1:0] t;
      logic [W+1:0] m_ext;
      m_ext = {2'b00, m_in};
      t = (acc_in << 1) + (add_b ? {2'b00, b_in} : '0);
      if (t >= m_ext) t = t - m_ext;
      if (t >= m_ext) t = t - m_ext;
      return t;
   endfunction

   assign p = acc[W-1:0];

   // Start consumes bit W-1; the busy phase walks bits W-2 down to 0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         acc  <= '0;
         idx  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (start) begin
         acc  <= mm_step('0, a[W-1], b, m);
         idx  <= CW'(W - 2);
         busy <= 1'b1;
         done <= 1'b0;
      end else if (busy) begin
         acc <= mm_step(acc, a[idx], b, m);
         idx <= idx - 1'b1;
         if (idx == '0) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/rsa_modexp_core.sv
// Constant-time modular exponentiation: RSA_result = RSA_data^RSA_exp mod RSA_mod.
// Handshake: a start is accepted on a rising edge where RSA_en_in=1 and
// RSA_ready=1; RSA_ready then drops until the result is presented, and
// RSA_result/RSA_err stay stable for as long as RSA_ready=1.
module rsa_modexp_core
   import rsa_pkg::*;
#(
   parameter int RSA_DATA_bw = RSA_DATA_BW_DEFAULT
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   RSA_en_in,
   input  logic [RSA_DATA_bw-1:0] RSA_data,
   input  logic [RSA_DATA_bw-1:0] RSA_exp,
   input  logic [RSA_DATA_bw-1:0] RSA_mod,
   output logic                   RSA_ready,
   output logic [RSA_DATA_bw-1:0] RSA_result,
   output logic                   RSA_err
);

   localparam int W  = RSA_DATA_bw;
   localparam int CW = $clog2(W);

   rsa_state_t    state;
   logic [W-1:0]  data_q;
   logic [W-1:0]  exp_q;
   logic [W-1:0]  mod_q;
   logic [W-1:0]  base_q;
   logic [W-1:0]  res_q;
   logic [W-1:0]  r_q;
   logic [CW-1:0] cnt;

   logic [W:0]    r_trial;
   logic [W-1:0]  r_next;
   logic          accept;
   logic          mul_start;
   logic          mul_done;
   logic          m1_busy, m1_done, m2_busy, m2_done;
   logic [W-1:0]  m1_p, m2_p;
   logic [31:0]   lat_cnt;

   assign accept    = (state == IDLE) && RSA_en_in && RSA_ready;
   // A new multiply pair launches whenever EXP has both multipliers fully idle,
   // which gives every exponent step exactly W+1 cycles.
   assign mul_start = (state == EXP) && !(m1_busy || m2_busy || m1_done || m2_done);
   assign mul_done  = m1_done && m2_done;

   // REDUCE step: r = 2r + next data bit, minus mod once if it reached mod.
   always_comb begin
      r_trial = {r_q, data_q[W-1]};
      r_next  = r_trial[W-1:0];
      if (r_trial >= {1'b0, mod_q}) r_next = W'(r_trial - {1'b0, mod_q});
   end

   rsa_modmul #(.W(W)) u_mul_res (
      .CLK(CLK), .RST(RST), .start(mul_start),
      .a(res_q), .b(base_q), .m(mod_q),
      .busy(m1_busy), .done(m1_done), .p(m1_p)
   );

   rsa_modmul #(.W(W)) u_mul_sq (
      .CLK(CLK), .RST(RST), .start(mul_start),
      .a(base_q), .b(base_q), .m(mod_q),
      .busy(m2_busy), .done(m2_done), .p(m2_p)
   );

   // Sequencer and datapath registers: IDLE -> LOAD -> REDUCE -> EXP -> DONE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         RSA_ready  <= 1'b0;
         RSA_result <= '0;
         RSA_err    <= 1'b0;
         data_q     <= '0;
         exp_q      <= '0;
         mod_q      <= '0;
         base_q     <= '0;
         res_q      <= '0;
         r_q        <= '0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  data_q    <= RSA_data;
                  exp_q     <= RSA_exp;
                  mod_q     <= RSA_mod;
                  RSA_ready <= 1'b0;
                  state     <= LOAD;
               end else begin
                  RSA_ready <= 1'b1;
               end
            end
            LOAD: begin
               res_q <= (mod_q == W'(1)) ? '0 : W'(1);
               r_q   <= '0;
               cnt   <= '0;
               state <= REDUCE;
            end
            REDUCE: begin
               r_q    <= r_next;
               data_q <= data_q << 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(W - 1)) begin
                  base_q <= r_next;
                  cnt    <= '0;
                  state  <= EXP;
               end
            end
            EXP: begin
               if (mul_done) begin
                  base_q <= m2_p;
                  if (exp_q[0]) res_q <= m1_p;
                  exp_q <= exp_q >> 1;
                  cnt   <= cnt + 1'b1;
                  if (cnt == CW'(W - 1)) begin
                     cnt   <= '0;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               RSA_result <= (mod_q == '0) ? '0 : res_q;
               RSA_err    <= (mod_q == '0);
               RSA_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Cycle counter from accept, cross-checked against the fixed latency in DONE.
   always_ff @(posedge CLK) begin
      if (RST) lat_cnt <= '0;
      else if (accept) lat_cnt <= 32'd1;
      else if (!RSA_ready) lat_cnt <= lat_cnt + 32'd1;
      if (!RST && state == DONE) assert (lat_cnt == 32'(rsa_latency(W)));
   end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed bench for rsa_modexp_core: reset, RSA textbook pair, back-to-back,
// boundary operands, mod==0 error flag and mid-operation reset.
module tb_rsa_modexp_core;
   import rsa_pkg::*;

   localparam int W       = 32;
   localparam int LAT     = rsa_latency(W);
   localparam int TIMEOUT = 3000;

   logic         CLK;
   logic         RST;
   logic         RSA_en_in;
   logic [W-1:0] RSA_data;
   logic [W-1:0] RSA_exp;
   logic [W-1:0] RSA_mod;
   logic         RSA_ready;
   logic [W-1:0] RSA_result;
   logic         RSA_err;

   int checks = 0;
   int errors = 0;

   rsa_modexp_core #(.RSA_DATA_bw(W)) dut (
      .CLK(CLK), .RST(RST), .RSA_en_in(RSA_en_in),
      .RSA_data(RSA_data), .RSA_exp(RSA_exp), .RSA_mod(RSA_mod),
      .RSA_ready(RSA_ready), .RSA_result(RSA_result), .RSA_err(RSA_err)
   );

   // Clock and reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Driver: waits for ready, issues one start, scrambles inputs while busy,
   // optionally pulses RSA_en_in mid-operation, and returns result and latency.
   task automatic run_op(input logic [W-1:0] d, input logic [W-1:0] e, input logic [W-1:0] m,
                         input bit pulse_busy,
                         output logic [W-1:0] res, output logic err, output int lat);
      int n;
      n = 0;
      res = '0;
      err = 1'b0;
      lat = -1;
      while (!RSA_ready && n < TIMEOUT) begin
         @(posedge CLK); #1;
         n++;
      end
      if (!RSA_ready) begin
         checks++; errors++;
         $display("FAIL ready_wait: RSA_ready=%b, required 1 within %0d cycles", RSA_ready, TIMEOUT);
         return;
      end
      RSA_data  = d;
      RSA_exp   = e;
      RSA_mod   = m;
      RSA_en_in = 1'b1;
      @(posedge CLK); #1;
      RSA_en_in = 1'b0;
      lat = 0;
      while (lat < TIMEOUT) begin
         RSA_data  = $urandom;
         RSA_exp   = $urandom;
         RSA_mod   = $urandom;
         RSA_en_in = (pulse_busy && lat == 200);
         @(posedge CLK); #1;
         lat++;
         if (pulse_busy && lat == 201) begin
            checks++;
            if (RSA_ready !== 1'b0) begin
               errors++;
               $display("FAIL busy_pulse: RSA_ready=%b, required 0", RSA_ready);
            end
         end
         if (RSA_ready === 1'b1) break;
      end
      RSA_en_in = 1'b0;
      if (RSA_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL done_wait: RSA_ready=%b, required 1 within %0d cycles", RSA_ready, TIMEOUT);
         return;
      end
      res = RSA_result;
      err = RSA_err;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      RSA_en_in = 1'b0;
      RSA_data = '0;
      RSA_exp = '0;
      RSA_mod = '0;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (RSA_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", RSA_ready); end
      checks++;
      if (RSA_result !== '0) begin errors++; $display("FAIL reset_result: got %0d, required 0", RSA_result); end
      checks++;
      if (RSA_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", RSA_err); end
      RST = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (RSA_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, required 1", RSA_ready); end
      checks++;
      if (RSA_result !== '0) begin errors++; $display("FAIL reset_release_result: got %0d, required 0", RSA_result); end
   endtask

   task automatic test_basic();
      logic [W-1:0] r; logic e; int lat;
      run_op(32'd65, 32'd17, 32'd3233, 1'b0, r, e, lat);
      checks++;
      if (r !== 32'd2790) begin errors++; $display("FAIL basic_result: got %0d, required 2790", r); end
      checks++;
      if (e !== 1'b0) begin errors++; $display("FAIL basic_err: got %b, required 0", e); end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d, required %0d", lat, LAT); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] r; logic e; int lat;
      // Called right after test_basic, so the accept lands on the first ready-high cycle.
      run_op(32'd2790, 32'd2753, 32'd3233, 1'b1, r, e, lat);
      checks++;
      if (r !== 32'd65) begin errors++; $display("FAIL b2b_result: got %0d, required 65", r); end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL b2b_latency: got %0d, required %0d", lat, LAT); end
      repeat (5) @(posedge CLK);
      #1;
      checks++;
      if (RSA_result !== 32'd65 || RSA_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_hold: result=%0d ready=%b, required 65 and 1", RSA_result, RSA_ready);
      end
   endtask

   task automatic test_edges();
      logic [W-1:0] vd [3] = '{32'd10, 32'd5, 32'd4000};
      logic [W-1:0] ve [3] = '{32'd0,  32'd3, 32'd1};
      logic [W-1:0] vm [3] = '{32'd7,  32'd1, 32'd3233};
      logic [W-1:0] vr [3] = '{32'd1,  32'd0, 32'd767};
      logic [W-1:0] r; logic e; int lat;
      for (int i = 0; i < 3; i++) begin
         run_op(vd[i], ve[i], vm[i], 1'b0, r, e, lat);
         checks++;
         if (r !== vr[i]) begin
            errors++;
            $display("FAIL edge%0d_result: %0d^%0d mod %0d got %0d, required %0d", i, vd[i], ve[i], vm[i], r, vr[i]);
         end
         checks++;
         if (e !== 1'b0) begin errors++; $display("FAIL edge%0d_err: got %b, required 0", i, e); end
      end
   endtask

   task automatic test_width();
      logic [W-1:0] r; logic e; int lat;
      run_op(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB, 1'b0, r, e, lat);
      checks++;
      if (r !== 32'd16) begin errors++; $display("FAIL width_result: got %0d, required 16", r); end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL width_latency: got %0d, required %0d", lat, LAT); end
   endtask

   task automatic test_mod_zero();
      logic [W-1:0] r; logic e; int lat;
      run_op(32'd3, 32'd5, 32'd0, 1'b0, r, e, lat);
      checks++;
      if (r !== '0) begin errors++; $display("FAIL modzero_result: got %0d, required 0", r); end
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL modzero_err: got %b, required 1", e); end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL modzero_latency: got %0d, required %0d", lat, LAT); end
      run_op(32'd10, 32'd0, 32'd7, 1'b0, r, e, lat);
      checks++;
      if (e !== 1'b0) begin errors++; $display("FAIL modzero_err_clear: got %b, required 0", e); end
      checks++;
      if (r !== 32'd1) begin errors++; $display("FAIL modzero_next_result: got %0d, required 1", r); end
   endtask

   task automatic test_mid_reset();
      logic [W-1:0] r; logic e; int lat;
      RSA_data  = 32'd65;
      RSA_exp   = 32'd17;
      RSA_mod   = 32'd3233;
      RSA_en_in = 1'b1;
      @(posedge CLK); #1;
      RSA_en_in = 1'b0;
      repeat (499) @(posedge CLK);
      #1;
      checks++;
      if (RSA_ready !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", RSA_ready); end
      RST = 1'b1;
      @(posedge CLK); #1;
      checks++;
      if (RSA_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b, required 0", RSA_ready); end
      checks++;
      if (RSA_result !== '0) begin errors++; $display("FAIL midrst_result: got %0d, required 0", RSA_result); end
      RST = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (RSA_ready !== 1'b1) begin errors++; $display("FAIL midrst_release: got %b, required 1", RSA_ready); end
      run_op(32'd65, 32'd17, 32'd3233, 1'b0, r, e, lat);
      checks++;
      if (r !== 32'd2790) begin errors++; $display("FAIL midrst_next_result: got %0d, required 2790", r); end
      checks++;
      if (lat != LAT) begin errors++; $display("FAIL midrst_latency: got %0d, required %0d", lat, LAT); end
   endtask

   // Test sequence and final report
   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_edges();
      test_width();
      test_mod_zero();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rsa_modexp_core.md
Name: rsa_modexp_core

Overview:
- Modular-exponentiation engine that sits directly downstream of the RSA input controller.
- Accepts one base word (from the input FIFO read data), plus exponent and modulus words, on a start pulse. Computes base^exp mod mod.
- Presents the result and raises RSA_ready; the controller uses the rising edge of RSA_ready to write the result into BRAM.
- Constant-time: latency is independent of operand values, which avoids timing side channels.

Parameters:
- RSA_DATA_bw, 32, width W of base, exponent, modulus and result.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- RSA_en_in  in  1  start pulse from the controller; accepted only while RSA_ready=1.
- RSA_data  in  W  base (FIFO read data); sampled on the accept cycle.
- RSA_exp  in  W  exponent; sampled on the accept cycle.
- RSA_mod  in  W  modulus; sampled on the accept cycle.
- RSA_ready  out  1  1 = idle with result valid (or idle after reset); 0 = busy.
- RSA_result  out  W  base^exp mod mod; held stable while RSA_ready=1.
- RSA_err  out  1  1 = last result came from mod==0; held with RSA_result.

Behaviour:
- Reset (RST=1 at a clock edge): RSA_ready=0, RSA_result=0, RSA_err=0, FSM=IDLE, all datapath registers cleared.
  - First cycle after RST deasserts: RSA_ready=1.
  - RST mid-operation aborts the operation; no partial result is ever presented.
- FSM states: IDLE -> LOAD -> REDUCE -> EXP -> DONE -> IDLE.
- IDLE, accept condition: RSA_en_in=1 and RSA_ready=1.
  - Capture data/exp/mod; RSA_ready=0 on the next cycle.
  - RSA_en_in while busy is ignored.
  - Input changes after the accept cycle are ignored.
- LOAD, 1 cycle:
  - res = (mod==1) ? 0 : 1.
  - bit counters cleared.
- REDUCE, W cycles: base = data mod mod, bit-serial MSB-first.
  - Per cycle: r = 2r + d[i]; if r >= mod then r -= mod.
  - r is W+1 bits wide.
- EXP, W steps of W+1 cycles each, exponent scanned LSB-first, right-to-left square-and-multiply.
  - Two rsa_modmul instances run in parallel: M1 = res*base mod m, M2 = base*base mod m.
  - Each takes W iteration cycles plus 1 done cycle.
  - On done: base <= M2; res <= exp[k] ? M1 : res.
  - Both multipliers always run, so timing is constant.
- DONE, 1 cycle:
  - RSA_result <= res; RSA_err <= (mod==0).
  - RSA_ready=1 from the next cycle.
- Latency: accept edge to RSA_ready rising = W*(W+2)+2 cycles, i.e. 1090 for W=32.
  - The next accept is allowed in the same cycle RSA_ready is first observed high.
- rsa_modmul algorithm (a*b mod m, requires a,b < m):
  - acc = 0; for i = W-1 downto 0: acc = 2*acc + (a[i] ? b : 0).
  - After each step, conditionally subtract m up to twice (acc < 3m).
  - acc is W+2 bits wide; the final value is < m.
- Boundary cases:
  - exp==0: result = 1 mod m.
  - mod==1: result 0.
  - data >= mod: handled by REDUCE.
  - mod==0: datapath output is don't-care; RSA_result forced to 0, RSA_err=1, latency unchanged.
  - mod==2^W-1: no overflow, by the width rules above.

Decomposition:
- Shared package rsa_pkg holds:
  - FSM state enum {IDLE, LOAD, REDUCE, EXP, DONE}.
  - Default RSA_DATA_bw.
  - Constant function rsa_latency(W) = W*(W+2)+2, used by both RTL assertions and the bench.
- Sub-module rsa_modmul, parameterised by W.
  - Ports: CLK, RST, start, a, b, m, busy, done, p.
  - Instantiated twice.
- The REDUCE datapath stays in the top level.

Test Plan:
- data=65, exp=17, mod=3233 -> RSA_result=2790, RSA_err=0, RSA_ready rises exactly 1090 cycles after accept.
- Back-to-back: data=2790, exp=2753, mod=3233 accepted on the first RSA_ready-high cycle -> 65; second start pulses asserted while busy are ignored.
- Edges:
  - data=10, exp=0, mod=7 -> 1.
  - data=5, exp=3, mod=1 -> 0.
  - data=4000, exp=1, mod=3233 -> 767.
- Width stress: data=0xFFFFFFFF, exp=2, mod=0xFFFFFFFB -> 16.
- data=3, exp=5, mod=0 -> RSA_result=0, RSA_err=1, latency 1090; a following valid op clears RSA_err.
- RST pulse 500 cycles into an operation -> RSA_ready=0 and RSA_result=0 during reset, RSA_ready=1 on the next cycle; a new op (65, 17, 3233) then yields 2790.
